// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states and the latched request.
package sram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic        write;
    logic [3:0]  strobe;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_winner,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_winner = 1'b0;
    if (i_req == 2'b11) begin
      o_winner = ~i_last_grant;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end
    o_valid = |i_req;
    o_gnt   = o_valid ? (2'b01 << o_winner) : 2'b00;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Fetch/data arbiter in front of a 1-cycle registered-read SRAM; each accepted
// request becomes exactly one SRAM cycle followed by a one-cycle response pulse.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int  MEM_SIZE_WORDS = 4096,
  parameter int  WAIT_STATES    = 0,
  localparam int ADDR_WIDTH     = $clog2(MEM_SIZE_WORDS)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS-1:0][3:0]   req_strobe,
  input  logic [NUM_PORTS-1:0][31:0]  req_addr,
  input  logic [NUM_PORTS-1:0][31:0]  req_wdata,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic                        rsp_err,
  output logic [31:0]                 rsp_rdata,
  output logic                        sram_valid,
  output logic                        sram_write,
  output logic [3:0]                  sram_strobe,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  output logic [31:0]                 sram_din,
  input  logic [31:0]                 sram_dout
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  sram_req_t  r_req;
  sram_req_t  w_sel;
  logic       r_last_grant;
  logic       r_err;
  logic [7:0] r_wait_cnt;
  logic       w_any;
  logic       w_winner;
  logic       w_accept;
  logic       w_access;
  logic [1:0] w_gnt;
  logic       w_unused_addr_lsb;

  rr_arbiter2 u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_valid      (w_any),
    .o_winner     (w_winner),
    .o_gnt        (w_gnt)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;

  always_comb begin
    w_sel        = '0;
    w_sel.write  = req_write[w_winner];
    w_sel.strobe = req_strobe[w_winner];
    w_sel.addr   = req_addr[w_winner];
    w_sel.wdata  = req_wdata[w_winner];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (r_wait_cnt == 8'd1) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // last_grant resets to 1 so port 0 takes the first tie; it also names the owner
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req        <= '0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      r_wait_cnt   <= 8'd0;
    end else if (w_accept) begin
      r_req        <= w_sel;
      r_last_grant <= w_winner;
      r_err        <= |w_sel.addr[31:ADDR_WIDTH+2];
      r_wait_cnt   <= WAIT_INIT;
    end else if (r_state == WAIT) begin
      r_wait_cnt   <= r_wait_cnt - 8'd1;
    end
  end

  assign w_access    = (r_state == ACCESS) && !r_err;
  assign sram_valid  = w_access;
  assign sram_write  = w_access && r_req.write;
  assign sram_strobe = (w_access && r_req.write) ? r_req.strobe : 4'h0;
  assign sram_addr   = w_access ? r_req.addr[ADDR_WIDTH+1:2] : '0;
  assign sram_din    = w_access ? r_req.wdata : 32'h0;

  assign rsp_valid = (r_state == RESP) ? (2'b01 << r_last_grant) : '0;
  assign rsp_err   = (r_state == RESP) && r_err;
  assign rsp_rdata = ((r_state == RESP) && !r_req.write && !r_err) ? sram_dout : 32'h0;

  // byte offset is deliberately ignored; alignment is the requester's problem
  assign w_unused_addr_lsb = ^r_req.addr[1:0];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (0 and 3 wait states) each with an SRAM model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int AW = 12;
  localparam int NW = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [1:0]        req_valid   [2];
  logic [1:0]        req_ready   [2];
  logic [1:0]        req_write   [2];
  logic [1:0][3:0]   req_strobe  [2];
  logic [1:0][31:0]  req_addr    [2];
  logic [1:0][31:0]  req_wdata   [2];
  logic [1:0]        rsp_valid   [2];
  logic              rsp_err     [2];
  logic [31:0]       rsp_rdata   [2];
  logic              sram_valid  [2];
  logic              sram_write  [2];
  logic [3:0]        sram_strobe [2];
  logic [AW-1:0]     sram_addr   [2];
  logic [31:0]       sram_din    [2];
  logic [31:0]       sram_dout   [2];

  sram_port_arbiter #(.MEM_SIZE_WORDS(NW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_strobe(req_strobe[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_valid(sram_valid[0]), .sram_write(sram_write[0]), .sram_strobe(sram_strobe[0]),
    .sram_addr(sram_addr[0]), .sram_din(sram_din[0]), .sram_dout(sram_dout[0])
  );

  sram_port_arbiter #(.MEM_SIZE_WORDS(NW), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_strobe(req_strobe[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_valid(sram_valid[1]), .sram_write(sram_write[1]), .sram_strobe(sram_strobe[1]),
    .sram_addr(sram_addr[1]), .sram_din(sram_din[1]), .sram_dout(sram_dout[1])
  );

  function automatic logic [31:0] preload_word(input int w);
    case (w)
      4:       return 32'hDEADBEEF;
      8:       return 32'h13579BDF;
      16:      return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  // SRAM models: registered read-first, per-byte strobes
  logic [31:0] smem [2][NW];
  bit preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < 2; k++)
        for (int w = 0; w < NW; w++) smem[k][w] <= preload_word(w);
      preloaded <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (sram_valid[k]) begin
        sram_dout[k] <= smem[k][sram_addr[k]];
        if (sram_write[k])
          for (int b = 0; b < 4; b++)
            if (sram_strobe[k][b]) smem[k][sram_addr[k]][8*b +: 8] <= sram_din[k][8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  // Behavioural model: a transaction accepted in cycle c touches the SRAM at
  // c+1+ws, responds at c+2+ws, and the port is free again at c+3+ws.
  logic [31:0] mmem [2][NW];
  bit          m_init = 1'b0;
  bit          m_pend [2];
  int          m_acc  [2];
  int          m_last [2];
  int          m_port [2];
  logic        m_w    [2];
  logic [3:0]  m_s    [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_d    [2];
  logic [31:0] m_rd   [2];
  bit          m_wr_pend [2];
  int          m_wr_word [2];
  logic [31:0] m_wr_data [2];
  int          sv_cnt [2];
  int          sv_cyc [2];
  int          sv_addr[2];

  task automatic model_step(input int k);
    int ws;
    int age;
    int win;
    bit exp_sv;
    logic [1:0] exp_rv;
    logic [1:0] exp_rdy;
    logic [31:0] word;
    ws = (k == 0) ? 0 : 3;
    if (!rstn) begin
      m_pend[k] = 1'b0; m_last[k] = 1; m_wr_pend[k] = 1'b0;
      chk("rst_req_ready", k, 32'(req_ready[k]), 0);
      chk("rst_sram_valid", k, 32'(sram_valid[k]), 0);
      chk("rst_sram_write", k, 32'(sram_write[k]), 0);
      chk("rst_sram_strobe", k, 32'(sram_strobe[k]), 0);
      chk("rst_sram_addr", k, 32'(sram_addr[k]), 0);
      chk("rst_sram_din", k, sram_din[k], 0);
      chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 0);
      chk("rst_rsp_err", k, 32'(rsp_err[k]), 0);
      chk("rst_rsp_rdata", k, rsp_rdata[k], 0);
      return;
    end
    if (m_wr_pend[k]) begin
      mmem[k][m_wr_word[k]] = m_wr_data[k];
      m_wr_pend[k] = 1'b0;
    end
    age = cyc - m_acc[k];
    if (m_pend[k] && age >= 3 + ws) m_pend[k] = 1'b0;

    exp_sv = m_pend[k] && (age == 1 + ws) && in_range(m_a[k]);
    chk("sram_valid", k, 32'(sram_valid[k]), 32'(exp_sv));
    if (exp_sv && sram_valid[k]) begin
      chk("sram_write", k, 32'(sram_write[k]), 32'(m_w[k]));
      chk("sram_strobe", k, 32'(sram_strobe[k]), m_w[k] ? 32'(m_s[k]) : 0);
      chk("sram_addr", k, 32'(sram_addr[k]), 32'(m_a[k][AW+1:2]));
      if (m_w[k]) chk("sram_din", k, sram_din[k], m_d[k]);
    end
    if (m_pend[k] && age == 1 + ws) begin
      m_rd[k] = 32'h0;
      if (in_range(m_a[k])) begin
        word = mmem[k][m_a[k][AW+1:2]];
        if (!m_w[k]) begin
          m_rd[k] = word;
        end else begin
          for (int b = 0; b < 4; b++) if (m_s[k][b]) word[8*b +: 8] = m_d[k][8*b +: 8];
          m_wr_pend[k] = 1'b1; m_wr_word[k] = int'(m_a[k][AW+1:2]); m_wr_data[k] = word;
        end
      end
    end

    exp_rv = (m_pend[k] && age == 2 + ws) ? 2'(1 << m_port[k]) : 2'b00;
    chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      chk("rsp_err", k, 32'(rsp_err[k]), in_range(m_a[k]) ? 0 : 1);
      chk("rsp_rdata", k, rsp_rdata[k], m_rd[k]);
    end

    exp_rdy = 2'b00;
    win = 0;
    if (!m_pend[k] && req_valid[k] != 2'b00) begin
      if (req_valid[k] == 2'b11) win = 1 - m_last[k];
      else win = req_valid[k][1] ? 1 : 0;
      exp_rdy = 2'(1 << win);
    end
    chk("req_ready", k, 32'(req_ready[k]), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      m_pend[k] = 1'b1; m_acc[k] = cyc; m_last[k] = win; m_port[k] = win;
      m_w[k] = req_write[k][win]; m_s[k] = req_strobe[k][win];
      m_a[k] = req_addr[k][win];  m_d[k] = req_wdata[k][win];
    end
  endtask

  always @(negedge clk) begin
    if (!m_init) begin
      for (int k = 0; k < 2; k++)
        for (int w = 0; w < NW; w++) mmem[k][w] = preload_word(w);
      m_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (sram_valid[k]) begin
        sv_cnt[k]++; sv_cyc[k] = cyc; sv_addr[k] = int'(sram_addr[k]);
      end
      model_step(k);
    end
  end

  int acc_port[$];
  int acc_cyc[$];

  task automatic issue(input int k, input int p, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, output int acc);
    req_write[k][p] = w; req_strobe[k][p] = s; req_addr[k][p] = a; req_wdata[k][p] = d;
    req_valid[k][p] = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[k][p]) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout inst%0d port%0d: got no ready want ready", k, p);
    end else begin
      acc_port.push_back(p); acc_cyc.push_back(acc);
    end
    @(posedge clk); #1;
    req_valid[k][p] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, input int p, output int c, output logic [31:0] rd, output logic er);
    c = -1; rd = 32'h0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[k][p]) begin c = cyc; rd = rsp_rdata[k]; er = rsp_err[k]; break; end
    end
    if (c < 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout inst%0d port%0d: got no rsp_valid want rsp_valid", k, p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, c, n0;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_write[k] = '0; req_strobe[k] = '0;
      req_addr[k] = '0;  req_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: port-0 load of word 4
    issue(0, 0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, a);
    wait_rsp(0, 0, c, rd, er);
    chk("t1_sram_lat", 0, sv_cyc[0] - a, 1);
    chk("t1_sram_addr", 0, sv_addr[0], 4);
    chk("t1_rsp_lat", 0, c - a, 2);
    chk("t1_rdata", 0, rd, 32'hDEADBEEF);
    chk("t1_err", 0, 32'(er), 0);

    // 2: partial store then read-back on port 1
    issue(0, 1, 1'b1, 4'b0101, 32'h8, 32'h11223344, a);
    wait_rsp(0, 1, c, rd, er);
    chk("t2_store_rdata", 0, rd, 0);
    issue(0, 1, 1'b0, 4'h0, 32'h8, 32'h0, a);
    wait_rsp(0, 1, c, rd, er);
    chk("t2_load_rdata", 0, rd, 32'h00220044);
    repeat (2) @(posedge clk); #1;

    // 3: both ports saturate the arbiter
    acc_port.delete(); acc_cyc.delete();
    fork
      for (int i = 0; i < 3; i++) begin
        int t;
        issue(0, 0, 1'b0, 4'h0, 32'h10, 32'h0, t);
      end
      for (int i = 0; i < 3; i++) begin
        int t;
        issue(0, 1, 1'b0, 4'h0, 32'h8 + 32'(4 * i), 32'h0, t);
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("t3_count", 0, acc_port.size(), 6);
    for (int i = 0; i < 6 && i < acc_port.size(); i++) chk("t3_grant", 0, acc_port[i], i % 2);
    for (int i = 1; i < 6 && i < acc_cyc.size(); i++) chk("t3_spacing", 0, acc_cyc[i] - acc_cyc[i-1], 3);

    // 4: three wait states
    n0 = sv_cnt[1];
    issue(1, 0, 1'b0, 4'h0, 32'h20, 32'h0, a);
    wait_rsp(1, 0, c, rd, er);
    chk("t4_rsp_lat", 1, c - a, 5);
    chk("t4_rdata", 1, rd, 32'h13579BDF);
    repeat (2) @(posedge clk); #1;
    chk("t4_sram_pulses", 1, sv_cnt[1] - n0, 1);

    // 5: out-of-range load
    n0 = sv_cnt[0];
    issue(0, 1, 1'b0, 4'h0, 32'h0001_0000, 32'h0, a);
    wait_rsp(0, 1, c, rd, er);
    chk("t5_err", 0, 32'(er), 1);
    chk("t5_rdata", 0, rd, 0);
    chk("t5_rsp_lat", 0, c - a, 2);
    repeat (2) @(posedge clk); #1;
    chk("t5_no_sram", 0, sv_cnt[0] - n0, 0);

    // 6: reset lands in ACCESS (inst0) and WAIT (inst1) of a port-0 store
    fork
      issue(0, 0, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF, a);
      issue(1, 0, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF, a1);
    join
    chk("t6_pre_access", 0, 32'(sram_valid[0]), 1);
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_sram_valid", k, 32'(sram_valid[k]), 0);
      chk("t6_sram_write", k, 32'(sram_write[k]), 0);
      chk("t6_sram_strobe", k, 32'(sram_strobe[k]), 0);
      chk("t6_sram_addr", k, 32'(sram_addr[k]), 0);
      chk("t6_sram_din", k, sram_din[k], 0);
      chk("t6_rsp_valid", k, 32'(rsp_valid[k]), 0);
    end
    repeat (3) @(posedge clk); #1;
    chk("t6_mem_kept", 0, smem[0][16], 32'hCAFEF00D);
    chk("t6_mem_kept", 1, smem[1][16], 32'hCAFEF00D);
    rstn = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("t6_mem_after", 1, smem[1][16], 32'hCAFEF00D);
    acc_port.delete(); acc_cyc.delete();
    fork
      issue(0, 0, 1'b0, 4'h0, 32'h10, 32'h0, a);
      issue(0, 1, 1'b0, 4'h0, 32'h20, 32'h0, a1);
    join
    chk("t6_first_tie", 0, (acc_port.size() > 0) ? acc_port[0] : -1, 0);
    repeat (5) @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
